// File: rtl/x7seg_pkg.sv
// Shared 7-segment constants and helpers for the display driver and
// the scan-side decoder.
package x7seg_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  function automatic logic is_onehot(
    input logic [NUM_DIGITS-1:0] v
  );
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/x7seg_scan_decode_if.sv
// Display bus seen by the scan decoder plus the reconstructed frame
// result; master is the driver/checker side, slave is the decoder.
interface x7seg_scan_decode_if;
  import x7seg_pkg::*;

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              a_to_g;
  logic [4*NUM_DIGITS-1:0] x;
  logic                    valid;
  logic                    err;

  modport master (
    output an,
    output a_to_g,
    input  x,
    input  valid,
    input  err
  );

  modport slave (
    input  an,
    input  a_to_g,
    output x,
    output valid,
    output err
  );

endinterface

// File: rtl/x7seg_seg2hex.sv
// Segment pattern to hex nibble; unknown patterns (blank included)
// give 0 with invalid set.
module x7seg_seg2hex
  import x7seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       invalid
);

  always_comb begin
    hex     = 4'h0;
    invalid = 1'b0;
    unique case (seg)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/x7seg_scan_decode.sv
// Samples a multiplexed 7-segment bus and rebuilds the displayed
// value, one valid pulse per completed 4-digit frame.
module x7seg_scan_decode
  import x7seg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 1
) (
  input logic                clk,
  input logic                clr_n,
  x7seg_scan_decode_if.slave bus
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int XW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  logic [W-1:0]          sync_q [SYNC_STAGES];
  logic [W-1:0]          sample;
  logic [W-1:0]          prev;
  logic [CW-1:0]         cnt;
  logic [CW-1:0]         cnt_nxt;
  logic                  accepted;
  logic                  acc_hold;
  logic                  accept;
  logic [NUM_DIGITS-1:0] s_an;
  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_all;
  logic [3:0]            nib;
  logic                  inv;
  logic                  bad;
  logic [XW-1:0]         shadow;
  logic [XW-1:0]         shadow_nxt;
  logic [XW-1:0]         x_q;
  logic                  valid_q;
  logic                  err_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {bus.an, bus.a_to_g};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign sample = sync_q[SYNC_STAGES-1];
  assign s_an   = sample[W-1:7];
  assign s_seg  = sample[6:0];

  x7seg_seg2hex u_dec (
    .seg     (s_seg),
    .hex     (nib),
    .invalid (inv)
  );

  // Accept on the sample where the run first reaches STABLE, once per run.
  always_comb begin
    cnt_nxt  = CW'(1);
    acc_hold = 1'b0;
    if (sample == prev) begin
      cnt_nxt  = (cnt == STABLE_C) ? cnt : cnt + 1'b1;
      acc_hold = accepted;
    end
  end

  assign accept   = (cnt_nxt == STABLE_C) && !acc_hold
                    && is_onehot(s_an);
  assign seen_all = seen | s_an;

  always_comb begin
    shadow_nxt = shadow;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s_an[i])
        shadow_nxt[4*i +: 4] = nib;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev     <= '0;
      cnt      <= '0;
      accepted <= 1'b0;
      seen     <= '0;
      bad      <= 1'b0;
      shadow   <= '0;
      x_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev     <= sample;
      cnt      <= cnt_nxt;
      accepted <= acc_hold | accept;
      valid_q  <= 1'b0;
      if (accept) begin
        shadow <= shadow_nxt;
        if (&seen_all) begin
          x_q     <= shadow_nxt;
          valid_q <= 1'b1;
          err_q   <= bad | inv;
          seen    <= '0;
          bad     <= 1'b0;
        end else begin
          seen <= seen_all;
          bad  <= bad | inv;
        end
      end
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_x7seg_scan_decode.sv
// Drives two decoders (STABLE=1 and STABLE=3) with the same bus and
// compares both against a run-length frame model every cycle.
module tb_x7seg_scan_decode;

  localparam int SYNC = 2;
  localparam int ST0  = 1;
  localparam int ST1  = 3;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  x7seg_scan_decode_if b0 ();
  x7seg_scan_decode_if b1 ();

  x7seg_scan_decode #(.SYNC_STAGES(SYNC), .STABLE(ST0)) u0 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (b0)
  );

  x7seg_scan_decode #(.SYNC_STAGES(SYNC), .STABLE(ST1)) u1 (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (b1)
  );

  logic [6:0] tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };
  int stab [2] = '{ST0, ST1};

  logic [10:0] pipe [2][SYNC];
  logic [10:0] prv [2];
  int          run [2];
  logic [3:0]  mseen [2];
  logic        mbad [2];
  logic [15:0] msh [2];
  logic [15:0] mx [2];
  logic        mv [2];
  logic        me [2];
  logic [10:0] cur;

  logic        dv [2];
  logic [15:0] dx [2];
  logic        de [2];
  assign dv[0] = b0.valid;
  assign dv[1] = b1.valid;
  assign dx[0] = b0.x;
  assign dx[1] = b1.x;
  assign de[0] = b0.err;
  assign de[1] = b1.err;

  int n_total = 0;
  int n_bad   = 0;
  int nv [2];

  task automatic decode(input logic [6:0] g,
                        output logic [3:0] h, output logic inv);
    h   = 4'h0;
    inv = 1'b1;
    for (int i = 0; i < 16; i++)
      if (tab[i] == g) begin
        h   = i[3:0];
        inv = 1'b0;
      end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < SYNC; i++) pipe[d][i] = '0;
      prv[d] = '0; run[d] = 0; mseen[d] = '0; mbad[d] = 1'b0;
      msh[d] = '0; mx[d] = '0; mv[d] = 1'b0; me[d] = 1'b0;
    end
  endtask

  // A pattern is taken once, when its run of identical samples reaches STABLE.
  task automatic model_edge();
    logic [10:0] s;
    logic [3:0]  h;
    logic        inv;
    for (int d = 0; d < 2; d++) begin
      s = pipe[d][SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) pipe[d][i] = pipe[d][i-1];
      pipe[d][0] = cur;
      run[d] = (s == prv[d]) ? run[d] + 1 : 1;
      prv[d] = s;
      mv[d]  = 1'b0;
      if (run[d] == stab[d] && $countones(s[10:7]) == 1) begin
        decode(s[6:0], h, inv);
        for (int i = 0; i < 4; i++)
          if (s[7+i]) msh[d][4*i +: 4] = h;
        mseen[d] = mseen[d] | s[10:7];
        if (mseen[d] == 4'hF) begin
          mx[d] = msh[d]; mv[d] = 1'b1; me[d] = mbad[d] | inv;
          mseen[d] = '0; mbad[d] = 1'b0;
        end else begin
          mbad[d] = mbad[d] | inv;
        end
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] g);
    cur       = {a, g};
    b0.an     = a;
    b0.a_to_g = g;
    b1.an     = a;
    b1.a_to_g = g;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int d = 0; d < 2; d++)
      if (dv[d]) nv[d]++;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    drive(4'h0, 7'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_total += 3;
      if (dx[d] !== 16'h0) begin n_bad++;
        $display("FAIL reset x d%0d got %h want 0000", d, dx[d]); end
      if (dv[d] !== 1'b0) begin n_bad++;
        $display("FAIL reset valid d%0d got %b want 0", d, dv[d]); end
      if (de[d] !== 1'b0) begin n_bad++;
        $display("FAIL reset err d%0d got %b want 0", d, de[d]); end
    end
    clr_n = 1'b1;
  endtask

  task automatic test_loopback();
    logic [3:0]  an_s [4];
    logic [6:0]  g_s [4];
    logic [15:0] lastx;
    int first, last;
    an_s = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    g_s  = '{7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000};
    nv = '{0, 0}; first = -1; last = -1; lastx = '0;
    for (int k = 0; k < 27; k++) begin
      if (k < 24) drive(an_s[k%4], g_s[k%4]);
      else drive(4'h0, 7'h00);
      step();
      if (dv[0]) begin
        if (first < 0) first = k;
        last = k; lastx = dx[0];
      end
      for (int d = 0; d < 2; d++) begin
        n_total += 3;
        if (dv[d] !== mv[d]) begin n_bad++;
          $display("FAIL loop valid d%0d k%0d got %b want %b", d, k, dv[d], mv[d]); end
        if (dx[d] !== mx[d]) begin n_bad++;
          $display("FAIL loop x d%0d k%0d got %h want %h", d, k, dx[d], mx[d]); end
        if (de[d] !== me[d]) begin n_bad++;
          $display("FAIL loop err d%0d k%0d got %b want %b", d, k, de[d], me[d]); end
      end
    end
    n_total += 4;
    if (nv[0] !== 6) begin n_bad++;
      $display("FAIL loop count got %0d want 6", nv[0]); end
    if (lastx !== 16'h1234) begin n_bad++;
      $display("FAIL loop value got %h want 1234", lastx); end
    if (first !== 5 || last - first !== 20) begin n_bad++;
      $display("FAIL loop spacing got first=%0d last=%0d want 5/25", first, last); end
    if (nv[1] !== 0) begin n_bad++;
      $display("FAIL loop stable3 count got %0d want 0", nv[1]); end
  endtask

  task automatic test_invalid();
    logic [10:0] seq [$];
    logic [15:0] vx [$];
    logic        ve [$];
    seq = '{ {4'b0001, 7'b0110011}, {4'b0010, 7'b1111001},
             {4'b0100, 7'b0000001}, {4'b1000, 7'b0110000},
             {4'b0001, 7'b0110011}, {4'b0010, 7'b1111001},
             {4'b0100, 7'b1101101}, {4'b1000, 7'b0110000},
             11'h0, 11'h0, 11'h0 };
    nv = '{0, 0};
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
      if (dv[0]) begin vx.push_back(dx[0]); ve.push_back(de[0]); end
      for (int d = 0; d < 2; d++) begin
        n_total += 3;
        if (dv[d] !== mv[d]) begin n_bad++;
          $display("FAIL inv valid d%0d k%0d got %b want %b", d, k, dv[d], mv[d]); end
        if (dx[d] !== mx[d]) begin n_bad++;
          $display("FAIL inv x d%0d k%0d got %h want %h", d, k, dx[d], mx[d]); end
        if (de[d] !== me[d]) begin n_bad++;
          $display("FAIL inv err d%0d k%0d got %b want %b", d, k, de[d], me[d]); end
      end
    end
    n_total++;
    if (vx.size() != 2) begin n_bad++;
      $display("FAIL inv count got %0d want 2", vx.size());
    end else begin
      n_total += 4;
      if (vx[0] !== 16'h1034) begin n_bad++;
        $display("FAIL inv x1 got %h want 1034", vx[0]); end
      if (ve[0] !== 1'b1) begin n_bad++;
        $display("FAIL inv err1 got %b want 1", ve[0]); end
      if (vx[1] !== 16'h1234) begin n_bad++;
        $display("FAIL inv x2 got %h want 1234", vx[1]); end
      if (ve[1] !== 1'b0) begin n_bad++;
        $display("FAIL inv err2 got %b want 0", ve[1]); end
    end
  endtask

  task automatic test_no_onehot();
    nv = '{0, 0};
    for (int k = 0; k < 40; k++) begin
      drive((k < 20) ? 4'b0000 : 4'b0011, tab[8]);
      step();
      for (int d = 0; d < 2; d++) begin
        n_total += 2;
        if (dv[d] !== mv[d]) begin n_bad++;
          $display("FAIL noh valid d%0d k%0d got %b want %b", d, k, dv[d], mv[d]); end
        if (dx[d] !== mx[d]) begin n_bad++;
          $display("FAIL noh x d%0d k%0d got %h want %h", d, k, dx[d], mx[d]); end
      end
    end
    n_total += 2;
    if (nv[0] + nv[1] !== 0) begin n_bad++;
      $display("FAIL noh count got %0d want 0", nv[0] + nv[1]); end
    if (dx[0] !== 16'h1234) begin n_bad++;
      $display("FAIL noh hold x got %h want 1234", dx[0]); end
  endtask

  task automatic test_stable3();
    logic [10:0] seq [$];
    int lat;
    seq = {};
    for (int i = 1; i < 4; i++)
      repeat (3) seq.push_back({4'(1 << i), tab[0]});
    repeat (2) seq.push_back({4'b0001, tab[5]});
    repeat (6) seq.push_back(11'h0);
    nv = '{0, 0};
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
      for (int d = 0; d < 2; d++) begin
        n_total += 2;
        if (dv[d] !== mv[d]) begin n_bad++;
          $display("FAIL st3a valid d%0d k%0d got %b want %b", d, k, dv[d], mv[d]); end
        if (dx[d] !== mx[d]) begin n_bad++;
          $display("FAIL st3a x d%0d k%0d got %h want %h", d, k, dx[d], mx[d]); end
      end
    end
    n_total++;
    if (nv[1] !== 0) begin n_bad++;
      $display("FAIL st3 glitch count got %0d want 0", nv[1]); end
    lat = -1;
    for (int k = 0; k < 8; k++) begin
      drive((k < 3) ? 4'b0001 : 4'b0000, (k < 3) ? tab[9] : 7'h00);
      step();
      if (dv[1] && lat < 0) lat = k;
      n_total += 2;
      if (dv[1] !== mv[1]) begin n_bad++;
        $display("FAIL st3b valid k%0d got %b want %b", k, dv[1], mv[1]); end
      if (dx[1] !== mx[1]) begin n_bad++;
        $display("FAIL st3b x k%0d got %h want %h", k, dx[1], mx[1]); end
    end
    n_total += 2;
    if (lat !== SYNC + ST1 - 1) begin n_bad++;
      $display("FAIL st3 latency got %0d want %0d", lat, SYNC + ST1 - 1); end
    if (dx[1] !== 16'h0009) begin n_bad++;
      $display("FAIL st3 x got %h want 0009", dx[1]); end
  endtask

  task automatic test_overwrite();
    logic [10:0] seq [$];
    seq = '{ {4'b0001, tab[5]}, {4'b0001, tab[7]}, {4'b0010, tab[0]},
             {4'b0100, tab[0]}, {4'b1000, tab[0]},
             11'h0, 11'h0, 11'h0 };
    nv = '{0, 0};
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
      n_total += 2;
      if (dv[0] !== mv[0]) begin n_bad++;
        $display("FAIL ovw valid k%0d got %b want %b", k, dv[0], mv[0]); end
      if (dx[0] !== mx[0]) begin n_bad++;
        $display("FAIL ovw x k%0d got %h want %h", k, dx[0], mx[0]); end
    end
    n_total += 2;
    if (dx[0] !== 16'h0007) begin n_bad++;
      $display("FAIL ovw value got %h want 0007", dx[0]); end
    if (nv[0] !== 1) begin n_bad++;
      $display("FAIL ovw count got %0d want 1", nv[0]); end
  endtask

  task automatic test_reset_mid();
    logic [10:0] seq [$];
    seq = '{ {4'b0001, tab[1]}, {4'b0010, tab[2]}, 11'h0, 11'h0 };
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
    end
    clr_n = 1'b0;
    #2;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      n_total += 3;
      if (dx[d] !== 16'h0) begin n_bad++;
        $display("FAIL rmid x d%0d got %h want 0000", d, dx[d]); end
      if (dv[d] !== 1'b0) begin n_bad++;
        $display("FAIL rmid valid d%0d got %b want 0", d, dv[d]); end
      if (de[d] !== 1'b0) begin n_bad++;
        $display("FAIL rmid err d%0d got %b want 0", d, de[d]); end
    end
    clr_n = 1'b1;
    seq = '{ {4'b0100, tab[3]}, {4'b1000, tab[4]}, 11'h0, 11'h0, 11'h0 };
    nv = '{0, 0};
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
    end
    n_total++;
    if (nv[0] !== 0) begin n_bad++;
      $display("FAIL rmid partial count got %0d want 0", nv[0]); end
    seq = '{ {4'b0001, tab[1]}, {4'b0010, tab[2]}, 11'h0, 11'h0, 11'h0 };
    foreach (seq[k]) begin
      drive(seq[k][10:7], seq[k][6:0]);
      step();
      n_total++;
      if (dv[0] !== mv[0]) begin n_bad++;
        $display("FAIL rmid valid k%0d got %b want %b", k, dv[0], mv[0]); end
    end
    n_total += 2;
    if (nv[0] !== 1) begin n_bad++;
      $display("FAIL rmid frame count got %0d want 1", nv[0]); end
    if (dx[0] !== 16'h4321) begin n_bad++;
      $display("FAIL rmid x got %h want 4321", dx[0]); end
  endtask

  task automatic test_random();
    logic [3:0] a;
    logic [6:0] g;
    int hold;
    hold = 0; a = '0; g = '0;
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 5);
        if ($urandom_range(0, 9) < 8) a = 4'(1 << $urandom_range(0, 3));
        else a = 4'($urandom);
        if ($urandom_range(0, 9) < 9) g = tab[$urandom_range(0, 15)];
        else g = 7'($urandom);
      end
      hold--;
      drive(a, g);
      step();
      for (int d = 0; d < 2; d++) begin
        n_total += 3;
        if (dv[d] !== mv[d]) begin n_bad++;
          $display("FAIL rnd valid d%0d k%0d got %b want %b", d, k, dv[d], mv[d]); end
        if (dx[d] !== mx[d]) begin n_bad++;
          $display("FAIL rnd x d%0d k%0d got %h want %h", d, k, dx[d], mx[d]); end
        if (de[d] !== me[d]) begin n_bad++;
          $display("FAIL rnd err d%0d k%0d got %b want %b", d, k, de[d], me[d]); end
      end
    end
  endtask

  initial begin
    nv = '{0, 0};
    test_reset();
    test_loopback();
    test_invalid();
    test_no_onehot();
    test_stable3();
    test_overwrite();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/x7seg_scan_decode.md
# x7seg_scan_decode

Scan-side decoder for a multiplexed 4-digit 7-segment bus. It samples the active-high one-hot anode and active-high `a_to_g` segment lines produced by our display driver and reconstructs the 16-bit hex value being shown. Each completed scan frame is reported with a one-cycle `valid` pulse. The block sits on the board-loopback and self-check path next to the display driver, and lets benches and on-chip checkers read back what is on the display.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: input register/synchronizer depth, minimum 1.
- `STABLE`, default 1: number of consecutive identical samples needed before a pattern is accepted, minimum 1. Use 1 with the sim-speed driver; use around 1024 on hardware.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `clr_n`  in  1: reset, asynchronous, active-low.
- `an`  in  4: anode lines. Active-high, one-hot. Bit i selects digit i, where digit i carries `x[4i+3:4i]`.
- `a_to_g`  in  7: segment lines, active-high. Bit 6 is segment a, bit 0 is segment g.
- `x`  out  16: last completed frame value.
- `valid`  out  1: one-cycle pulse when `x` updates.
- `err`  out  1: set with `valid` if any digit in that frame had an unrecognised pattern. Holds until the next `valid`.

## Operation
- Input path: the concatenation {`an`,`a_to_g`} passes through `SYNC_STAGES` registers. The final stage output is the "sample".
- Stability counter: if sample equals the previous sample, the counter increments, saturating at `STABLE`. Otherwise the counter loads 1 and `accepted` clears.
- Accept event: fires when counter == `STABLE` and `accepted` = 0, and `an` is one-hot. On an accept event, `accepted` sets, so a held pattern is captured only once.
- Anode value 0000 or multi-hot: no accept. The counter still runs.
- Segment decode, pattern to hex digit:
  - 0: 1111110
  - 1: 0110000
  - 2: 1101101
  - 3: 1111001
  - 4: 0110011
  - 5: 1011011
  - 6: 1011111
  - 7: 1110000
  - 8: 1111111
  - 9: 1111011
  - A: 1110111
  - b: 0011111
  - C: 1001110
  - d: 0111101
  - E: 1001111
  - F: 1000111
- Any other pattern, including blank 0000000, is invalid: it decodes to 0 and sets `bad`.
- Capture: on accept, `shadow[i]` gets the decoded nibble and `seen[i]` sets. If position i was already seen in this frame, the newer value overwrites it.
- Frame complete: when `seen` including the current capture equals 1111, on the same edge:
  - `x` loads the shadow, including the current nibble;
  - `valid` goes to 1;
  - `err` loads `bad` OR the current capture's invalid flag;
  - `seen` and `bad` clear.
- Capture order is free. The driver scans 0,1,2,3, but any order completes a frame.

## Timing
- Reset values: `x`=0, `valid`=0, `err`=0. Internally, the sync regs, counter, `accepted`, `seen`, `bad` and `shadow` are all 0.
- Reset applies asynchronously. Release is synchronous to `clk` through the normal flop behaviour.
- Latency: a pattern first present at the inputs before edge n is accepted at edge n+`SYNC_STAGES`+`STABLE`−1. A frame-completing accept raises `valid` on that same edge.
- `valid` is high for exactly one cycle. With `STABLE`=1 and a driver advancing every cycle, a new frame completes every 4 cycles.
- A pattern held for fewer than `STABLE` samples is never captured. This rejects glitches.
- Reset mid-frame discards partial captures. A full 4-digit frame is needed after release.
- Back-to-back frames have no dead cycle: the accept that starts frame k+1 may occur on the cycle right after frame k's `valid`.

## Structure
- Shared package `x7seg_pkg` holds:
  - segment pattern constants `SEG_0`..`SEG_F`, shared with the display driver;
  - `NUM_DIGITS`=4.
- Sub-module `x7seg_seg2hex`: combinational, input 7-bit pattern, outputs 4-bit hex and 1-bit `invalid`. It is reusable by other checkers.
- Top level holds the sync chain, stability counter, capture/frame logic and output registers.

## Test plan
- Loopback with value 16'h1234, `STABLE`=1, scanning every cycle:
  - stimulus: an 0001 with 0110011, then 0010 with 1111001, then 0100 with 1101101, then 1000 with 0110000;
  - response: `valid` pulses once with `x`=16'h1234, `err`=0, and repeats every 4 cycles.
- Invalid pattern 0000001 on an=0100 with the other three digits valid (value 16'h1234) → `valid`, `x`=16'h1034, `err`=1. The next clean frame gives `err`=0.
- `an` held at 0000, then at 0011, with valid segments for 20 cycles → no `valid`, and `x` unchanged.
- `STABLE`=3:
  - a digit-0 pattern held 2 cycles, then changed → not captured;
  - held 3 cycles → captured after exactly `SYNC_STAGES`+3−1 edges.
- Digit 0 shown as 5, then 7, before digits 1–3 (all 0) → `x`=16'h0007.
- `clr_n` pulsed low after 2 digits captured → `x`=0, `valid`=0, `err`=0 immediately. The first `valid` after release comes only after 4 new captures.
